approx_mac_pipe: RTL and testbench

//  Parametrised, pipelined multiply-accumulate engine for the approximate-MAC datapath.
//  - Consumes a stream of unsigned WIDTH x WIDTH operand pairs over a valid/ready handshake.
//  - Accumulates N_TERMS products into one dot-product result, then presents the result
//    on a valid/ready output handshake.
//  - A per-beat approx_en flag truncates the low-order partial-product columns.
//  - Replaces the compare-with-previous-input accumulation scheme with explicit handshakes.

---
 rtl/approx_mac_pipe_pkg.sv | 24 ++
 rtl/approx_mac_pipe_pp_mult.sv | 41 ++++
 rtl/approx_mac_pipe.sv | 167 ++++++++++++++++
 tb/tb_approx_mac_pipe.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/approx_mac_pipe_pkg.sv
// Shared types and helpers for the approximate multiply-accumulate pipeline.
// The column mask decides which partial products survive in truncated mode.
package approx_mac_pkg;

  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam int ACC_W_DFLT = 20;
  localparam logic [ACC_W_DFLT-1:0] ACC_MAX = {ACC_W_DFLT{1'b1}};

  // 1 = keep partial product a[i]&b[j]; low columns drop out in approx mode
  function automatic logic pp_mask(input int i, input int j, input logic approx_en,
                                   input int approx_cols);
    if (approx_en && ((i + j) < approx_cols)) begin
      return 1'b0;
    end else begin
      return 1'b1;
    end
  endfunction

endpackage

// File: rtl/approx_mac_pipe_pp_mult.sv
// Combinational unsigned multiplier: masked AND-array partial products reduced
// row by row with 3:2 carry-save full adders, then one final carry-propagate add.
module pp_mult
  import approx_mac_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int APPROX_COLS = 4
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               approx_en,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW = 2 * WIDTH;

  logic [PW-1:0] row_s;
  logic [PW-1:0] sum_s;
  logic [PW-1:0] carry_s;
  logic [PW-1:0] sum_nxt_s;

  // Carry-save reduction; bits shifted past PW are dropped, which is safe
  // because the true product always fits in PW bits.
  always_comb begin
    row_s     = '0;
    sum_s     = '0;
    carry_s   = '0;
    sum_nxt_s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      row_s = '0;
      for (int j = 0; j < WIDTH; j++) begin
        row_s[i+j] = a[i] & b[j] & pp_mask(i, j, approx_en, APPROX_COLS);
      end
      sum_nxt_s = sum_s ^ carry_s ^ row_s;
      carry_s   = ((sum_s & carry_s) | (sum_s & row_s) | (carry_s & row_s)) << 1;
      sum_s     = sum_nxt_s;
    end
    product = sum_s + carry_s;
  end

endmodule

// File: rtl/approx_mac_pipe.sv
// Pipelined saturating dot-product engine: N_TERMS operand beats in over valid/ready,
// one accumulated result out over valid/ready. Product -> S1 -> S2 -> accumulator.
module approx_mac_pipe
  import approx_mac_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int ACC_W       = 20,
  parameter int N_TERMS     = 4,
  parameter int APPROX_COLS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             approx_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_sat,
  output logic             busy
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = $clog2(N_TERMS + 1);
  localparam logic [ACC_W-1:0] ACC_LIMIT = {ACC_W{1'b1}};
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(N_TERMS - 1);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] count_r;
  logic             s1_valid_r;
  logic             s2_valid_r;
  logic [PW-1:0]    prod_s;
  logic [PW-1:0]    s1_prod_r;
  logic [PW-1:0]    s2_prod_r;
  logic [ACC_W-1:0] acc_r;
  logic             sat_r;
  logic [ACC_W:0]   sum_s;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [ACC_W-1:0] out_data_r;
  logic             out_sat_r;
  logic             accept_s;
  logic             pipe_empty_s;
  logic             release_s;

  pp_mult #(
    .WIDTH       (WIDTH),
    .APPROX_COLS (APPROX_COLS)
  ) u_pp_mult (
    .a         (in_a),
    .b         (in_b),
    .approx_en (approx_en),
    .product   (prod_s)
  );

  assign accept_s     = in_valid & in_ready_r;
  assign pipe_empty_s = ~s1_valid_r & ~s2_valid_r;
  assign release_s    = out_valid_r & out_ready;
  // One spare top bit catches overflow for saturation.
  assign sum_s        = {1'b0, acc_r} + {{(ACC_W + 1 - PW){1'b0}}, s2_prod_r};

  // Next-state decode
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_ACC: begin
        if (accept_s && (count_r == LAST_CNT)) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_ACC;
        end
      end
      ST_DRAIN: begin
        if (pipe_empty_s) begin
          state_nxt_s = ST_HOLD;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_HOLD: begin
        if (release_s) begin
          state_nxt_s = ST_ACC;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: state_nxt_s = ST_ACC;
    endcase
  end

  // FSM state, beat counter and registered in_ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_ACC;
      count_r    <= '0;
      in_ready_r <= 1'b1;
    end else begin
      state_r    <= state_nxt_s;
      in_ready_r <= (state_nxt_s == ST_ACC);
      if (accept_s) begin
        count_r <= (count_r == LAST_CNT) ? '0 : count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Product pipeline S1 -> S2; never stalls since in_ready drops while draining
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_prod_r  <= '0;
      s2_valid_r <= 1'b0;
      s2_prod_r  <= '0;
    end else begin
      s1_valid_r <= accept_s;
      s2_valid_r <= s1_valid_r;
      if (accept_s) begin
        s1_prod_r <= prod_s;
      end
      if (s1_valid_r) begin
        s2_prod_r <= s1_prod_r;
      end
    end
  end

  // Saturating accumulator with sticky saturation flag, cleared on result accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= '0;
      sat_r <= 1'b0;
    end else if (release_s) begin
      acc_r <= '0;
      sat_r <= 1'b0;
    end else if (s2_valid_r) begin
      if (sum_s[ACC_W]) begin
        acc_r <= ACC_LIMIT;
        sat_r <= 1'b1;
      end else begin
        acc_r <= sum_s[ACC_W-1:0];
      end
    end
  end

  // Result register: loaded once the pipe has drained, held until accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_sat_r   <= 1'b0;
    end else if ((state_r == ST_DRAIN) && pipe_empty_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= acc_r;
      out_sat_r   <= sat_r;
    end else if (release_s) begin
      out_valid_r <= 1'b0;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_sat   = out_sat_r;
  assign busy      = (state_r != ST_ACC) | s1_valid_r | s2_valid_r;

endmodule

// File: tb/tb_approx_mac_pipe.sv
// Self-checking bench: a 20-bit and a 17-bit accumulator instance run in lockstep
// on shared stimulus and are compared against an arithmetic reference model.
module tb_approx_mac_pipe;

  localparam longint MAX20 = 64'd1048575;
  localparam longint MAX17 = 64'd131071;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        approx_en;
  logic        out_ready;
  logic        in_ready, out_valid, out_sat, busy;
  logic [19:0] out_data;
  logic        in_ready_s, out_valid_s, out_sat_s, busy_s;
  logic [16:0] out_data_s;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int qa[$];
  int qb[$];
  bit qap[$];

  approx_mac_pipe #(.WIDTH(8), .ACC_W(20), .N_TERMS(4), .APPROX_COLS(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .approx_en(approx_en), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat), .busy(busy)
  );

  approx_mac_pipe #(.WIDTH(8), .ACC_W(17), .N_TERMS(4), .APPROX_COLS(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_a(in_a), .in_b(in_b), .approx_en(approx_en), .out_valid(out_valid_s),
    .out_ready(out_ready), .out_data(out_data_s), .out_sat(out_sat_s), .busy(busy_s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input string what, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s.%s: observed %0d expected %0d", tag, what, got, exp);
    end
  endtask

  // Product as the sum of all surviving a[i]*b[j]*2^(i+j) terms
  function automatic longint model_prod(input int a, input int b, input bit ap);
    longint p = 0;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        if (((a >> i) & 1) == 1 && ((b >> j) & 1) == 1 && !(ap && (i + j) < 4))
          p += longint'(1) << (i + j);
      end
    end
    return p;
  endfunction

  task automatic push(input int a, input int b, input bit ap);
    qa.push_back(a);
    qb.push_back(b);
    qap.push_back(ap);
  endtask

  // Sends queued beats starting at a negedge; ends at the negedge after the last accept
  task automatic send_beats(input int max_gap, input string tag, output longint total);
    total = 0;
    for (int k = 0; k < qa.size(); k++) begin
      int gap;
      gap = int'($urandom_range(max_gap, 0));
      repeat (gap) begin
        in_valid  = 1'b0;
        in_a      = 8'($urandom);
        in_b      = 8'($urandom);
        approx_en = 1'($urandom);
        @(negedge clk);
      end
      in_valid  = 1'b1;
      in_a      = 8'(qa[k]);
      in_b      = 8'(qb[k]);
      approx_en = qap[k];
      chk(tag, "beat_in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      total += model_prod(qa[k], qb[k], qap[k]);
    end
    qa.delete();
    qb.delete();
    qap.delete();
  endtask

  // Checks latency, result, optional backpressure window and the release handshake
  task automatic finish_result(input longint total, input int hold_cycles, input string tag);
    longint e20, e17;
    e20 = (total > MAX20) ? MAX20 : total;
    e17 = (total > MAX17) ? MAX17 : total;
    chk(tag, "valid_e0", {31'd0, out_valid}, 32'd0);
    repeat (2) @(negedge clk);
    chk(tag, "valid_e2", {31'd0, out_valid}, 32'd0);
    chk(tag, "busy_e2", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk(tag, "valid_e3", {31'd0, out_valid}, 32'd1);
    chk(tag, "valid_e3_s", {31'd0, out_valid_s}, 32'd1);
    chk(tag, "data20", {12'd0, out_data}, 32'(e20));
    chk(tag, "sat20", {31'd0, out_sat}, {31'd0, total > MAX20});
    chk(tag, "data17", {15'd0, out_data_s}, 32'(e17));
    chk(tag, "sat17", {31'd0, out_sat_s}, {31'd0, total > MAX17});
    chk(tag, "hold_in_ready", {31'd0, in_ready}, 32'd0);
    if (out_ready == 1'b0) begin
      for (int h = 0; h < hold_cycles; h++) begin
        in_valid  = 1'b1;
        in_a      = 8'($urandom);
        in_b      = 8'($urandom);
        approx_en = 1'($urandom);
        @(negedge clk);
        chk(tag, "bp_valid", {31'd0, out_valid}, 32'd1);
        chk(tag, "bp_data", {12'd0, out_data}, 32'(e20));
        chk(tag, "bp_in_ready", {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
    end
    chk(tag, "hs_in_ready_same", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk(tag, "rel_valid", {31'd0, out_valid}, 32'd0);
    chk(tag, "rel_valid_s", {31'd0, out_valid_s}, 32'd0);
    chk(tag, "rel_in_ready", {31'd0, in_ready}, 32'd1);
    chk(tag, "rel_busy", {31'd0, busy}, 32'd0);
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic run(input int max_gap, input int hold_cycles, input bit early,
                     input string tag);
    longint total;
    out_ready = early;
    send_beats(max_gap, tag, total);
    finish_result(total, early ? 0 : hold_cycles, tag);
  endtask

  // Asserts reset off the clock edge, checks reset values, releases at the next negedge
  task automatic do_reset(input string tag);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk(tag, "rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk(tag, "rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk(tag, "rst_out_data", {12'd0, out_data}, 32'd0);
    chk(tag, "rst_out_sat", {31'd0, out_sat}, 32'd0);
    chk(tag, "rst_busy", {31'd0, busy}, 32'd0);
    chk(tag, "rst_in_ready_s", {31'd0, in_ready_s}, 32'd1);
    chk(tag, "rst_out_valid_s", {31'd0, out_valid_s}, 32'd0);
    chk(tag, "rst_out_data_s", {15'd0, out_data_s}, 32'd0);
    chk(tag, "rst_out_sat_s", {31'd0, out_sat_s}, 32'd0);
    chk(tag, "rst_busy_s", {31'd0, busy_s}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    longint total;
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_a      = 8'd0;
    in_b      = 8'd0;
    approx_en = 1'b0;
    out_ready = 1'b0;
    #2;
    do_reset("init");

    // Exact full-scale products; the 17-bit instance saturates
    repeat (4) push(255, 255, 1'b0);
    run(0, 0, 1'b0, "exact_sat");
    repeat (4) push(1, 1, 1'b0);
    run(0, 0, 1'b0, "after_sat");

    // Truncated products, then one exact plus three truncated
    repeat (4) push(15, 15, 1'b1);
    run(0, 0, 1'b0, "approx");
    push(15, 15, 1'b0);
    repeat (3) push(15, 15, 1'b1);
    run(1, 0, 1'b0, "mixed");

    // Backpressure with ignored beats while holding
    repeat (4) push(int'($urandom_range(255, 0)), int'($urandom_range(255, 0)), 1'b0);
    run(0, 5, 1'b0, "backpressure");

    // Gapped input for increasing maximum gap
    for (int g = 0; g <= 3; g++) begin
      push(3, 7, 1'b0);
      push(2, 2, 1'b0);
      push(0, 9, 1'b0);
      push(10, 10, 1'b0);
      run(g, 1, 1'b0, "gapped");
    end

    // Consumer ready before the result exists
    repeat (4) push(100, 3, 1'b0);
    run(2, 0, 1'b1, "early_ready");

    // Reset mid-accumulation discards partial sum
    repeat (2) push(200, 200, 1'b0);
    send_beats(0, "mid_acc", total);
    do_reset("mid_acc");
    repeat (4) push(1, 1, 1'b0);
    run(0, 0, 1'b0, "post_reset");

    // Reset while a result is pending
    repeat (4) push(50, 60, 1'b0);
    send_beats(0, "mid_hold", total);
    repeat (3) @(negedge clk);
    chk("mid_hold", "pending_valid", {31'd0, out_valid}, 32'd1);
    do_reset("mid_hold");

    // Randomized results
    for (int r = 0; r < 10; r++) begin
      repeat (4) push(int'($urandom_range(255, 0)), int'($urandom_range(255, 0)),
                      1'($urandom));
      run(2, int'($urandom_range(3, 0)), 1'($urandom), "random");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
